// File: rtl/serial_full_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: a start/done handshake
// carrying a, b, bin in and diff, bout, ovf out.
interface serial_full_subtractor_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell and a registered
// borrow; WIDTH cycles per operation under a start/done handshake.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_full_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             load, last;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic [CW-1:0]    cnt;
  logic             brw, brw_next, brw_msb, d;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_next = RUN;
        load       = 1'b1;
      end
      RUN: if (cnt == LAST) begin
        state_next = DONE;
        last       = 1'b1;
      end
      DONE: begin
        if (bus.start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs
  always_comb begin
    d        = a_sr[0] ^ b_sr[0] ^ brw;
    brw_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  end

  generate
    if (WIDTH == 1) begin : g_res1
      assign res_next = d;
    end else begin : g_resn
      assign res_next = {d, res_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      cnt     <= '0;
      brw     <= 1'b0;
      brw_msb <= 1'b0;
      diff_r  <= '0;
      bout_r  <= 1'b0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      brw    <= bus.bin;
      cnt    <= '0;
      res_sr <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      brw    <= brw_next;
      res_sr <= res_next;
      cnt    <= cnt + CW'(1);
      if (last) begin
        brw_msb <= brw;
        diff_r  <= res_next;
        bout_r  <= brw_next;
      end
    end
  end

  // ovf is decoded from the two registered borrows, so it changes only
  // when they do: on completion or reset.
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_r;
  assign bus.bout = bout_r;
  assign bus.ovf  = brw_msb ^ bout_r;

endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed, table-driven bench for serial_full_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_full_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_full_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_full_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_full_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_full_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic bin);
    if (w1) begin
      bus1.start = 1'b1; bus1.a = a[0]; bus1.b = b[0]; bus1.bin = bin;
    end else begin
      bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
    end
  endtask

  // Advances edges from a launch until done, returning edge count and busy count.
  task automatic wait_done(input bit w1, input string tag, output int n, output int nbusy);
    logic dn;
    n = 0;
    nbusy = 0;
    dn = 1'b0;
    while (!dn && n < 40) begin
      tick();
      bus8.start = 1'b0;
      bus1.start = 1'b0;
      n++;
      dn = w1 ? bus1.done : bus8.done;
      if (!dn && (w1 ? bus1.busy : bus8.busy)) nbusy++;
    end
    if (!dn) begin
      errors++;
      $display("FAIL %s_timeout: got no done expected done", tag);
    end
  endtask

  task automatic check_result(input bit w1, input string tag, input vec_t v);
    if (w1) begin
      check({tag, "_diff"}, {31'd0, bus1.diff}, {31'd0, v.diff[0]});
      check({tag, "_bout"}, {31'd0, bus1.bout}, {31'd0, v.bout});
      check({tag, "_ovf"},  {31'd0, bus1.ovf},  {31'd0, v.ovf});
    end else begin
      check({tag, "_diff"}, {24'd0, bus8.diff}, {24'd0, v.diff});
      check({tag, "_bout"}, {31'd0, bus8.bout}, {31'd0, v.bout});
      check({tag, "_ovf"},  {31'd0, bus8.ovf},  {31'd0, v.ovf});
    end
  endtask

  task automatic check_zero8(input string tag);
    check({tag, "_busy"}, {31'd0, bus8.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus8.done}, 32'd0);
    check({tag, "_diff"}, {24'd0, bus8.diff}, 32'd0);
    check({tag, "_bout"}, {31'd0, bus8.bout}, 32'd0);
    check({tag, "_ovf"},  {31'd0, bus8.ovf},  32'd0);
  endtask

  vec_t t8 [6];
  vec_t t1 [8];

  initial begin
    int n, nb, ndone;

    t8[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    t8[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    t8[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    t8[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    t8[4] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    t8[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};

    // {a,b,bin} = i; diff, bout, ovf = bin ^ bout
    t1[0] = '{8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
    t1[1] = '{8'd0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0};
    t1[2] = '{8'd0, 8'd1, 1'b0, 8'd1, 1'b1, 1'b1};
    t1[3] = '{8'd0, 8'd1, 1'b1, 8'd0, 1'b1, 1'b0};
    t1[4] = '{8'd1, 8'd0, 1'b0, 8'd1, 1'b0, 1'b0};
    t1[5] = '{8'd1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1};
    t1[6] = '{8'd1, 8'd1, 1'b0, 8'd0, 1'b0, 1'b0};
    t1[7] = '{8'd1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0};

    bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = 1'b1;
    bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.bin = 1'b0;

    // Reset held with start asserted
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero8($sformatf("rst%0d", i));
    end
    bus8.start = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    check_zero8("post_rst");

    // Single operation from idle
    launch(1'b0, t8[0].a, t8[0].b, t8[0].bin);
    wait_done(1'b0, "single", n, nb);
    check("single_latency", n, 32'd9);
    check("single_busy_cycles", nb, 32'd8);
    check_result(1'b0, "single", t8[0]);
    tick();
    check("single_done_once", {31'd0, bus8.done}, 32'd0);
    check("single_hold", {24'd0, bus8.diff}, 32'h02);

    // Back-to-back chain: next start asserted in each DONE cycle
    tick();
    launch(1'b0, t8[1].a, t8[1].b, t8[1].bin);
    wait_done(1'b0, "b2b1", n, nb);
    check_result(1'b0, "b2b1", t8[1]);
    for (int i = 2; i < 6; i++) begin
      launch(1'b0, t8[i].a, t8[i].b, t8[i].bin);
      wait_done(1'b0, $sformatf("b2b%0d", i), n, nb);
      check($sformatf("b2b%0d_spacing", i), n, 32'd9);
      check_result(1'b0, $sformatf("b2b%0d", i), t8[i]);
    end
    tick();

    // Start while busy is ignored
    launch(1'b0, 8'h10, 8'h01, 1'b0);
    tick(); bus8.start = 1'b0;
    tick(); tick();
    launch(1'b0, 8'hFF, 8'hFF, 1'b0);
    tick();
    bus8.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.done) begin
        ndone++;
        check("busy_start_diff", {24'd0, bus8.diff}, 32'h0F);
        check("busy_start_bout", {31'd0, bus8.bout}, 32'd0);
        check("busy_start_ovf",  {31'd0, bus8.ovf},  32'd0);
      end
      tick();
    end
    check("busy_start_ndone", ndone, 32'd1);
    check("busy_start_hold", {24'd0, bus8.diff}, 32'h0F);
    check("busy_start_idle", {31'd0, bus8.busy}, 32'd0);

    // Reset mid-operation aborts and clears outputs
    launch(1'b0, 8'h7F, 8'h80, 1'b0);
    tick(); bus8.start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_zero8("midrst");
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done) ndone++;
    end
    check("midrst_no_done", ndone, 32'd0);
    check_zero8("midrst_after");
    launch(1'b0, t8[4].a, t8[4].b, t8[4].bin);
    wait_done(1'b0, "fresh", n, nb);
    check("fresh_latency", n, 32'd9);
    check_result(1'b0, "fresh", t8[4]);
    tick();

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      launch(1'b1, t1[i].a, t1[i].b, t1[i].bin);
      wait_done(1'b1, $sformatf("w1_%0d", i), n, nb);
      check($sformatf("w1_%0d_latency", i), n, 32'd2);
      check($sformatf("w1_%0d_busy", i), nb, 32'd1);
      check_result(1'b1, $sformatf("w1_%0d", i), t1[i]);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
